// File: rtl/mips_rf_pkg.sv
// Shared types and helpers for the multi-port MIPS register file.
package mips_rf_pkg;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_e;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;

    // LSB of port p's field inside a flattened per-port bus.
    function automatic int port_lsb(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/mips_rf_wr_arb.sv
// Resolves which write port (if any) targets a queried address; the highest index wins.
module mips_rf_wr_arb
    import mips_rf_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int NUM_WR = 2
) (
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0]        q_addr,
    output logic                     hit,
    output logic [DATA_W-1:0]        data
);

    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en[w] && wr_addr[port_lsb(w, ADDR_W) +: ADDR_W] == q_addr) begin
                hit  = 1'b1;
                data = wr_data[port_lsb(w, DATA_W) +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/mips_regfile_mp.sv
// Multi-port register file: registered reads with write-first bypass,
// per-register pending bits, and a post-reset clear sweep.
module mips_regfile_mp
    import mips_rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_pend,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic                     pend_set,
    input  logic [ADDR_W-1:0]        pend_addr,
    output logic                     init_done
);

    localparam int DEPTH = 2 ** ADDR_W;

    rf_state_e         state_q, state_d;
    logic [ADDR_W-1:0] cnt_q;
    logic              run;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RF_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == RF_CLEAR) cnt_q <= cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        run     = (state_q == RF_RUN);
        if (state_q == RF_CLEAR && (&cnt_q)) state_d = RF_RUN;
    end

    assign init_done = run;

    logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
    logic [DEPTH-1:0]             pend_q, pend_d;
    logic [DEPTH-1:0]             ent_hit;
    logic [DEPTH-1:0][DATA_W-1:0] ent_data;

    for (genvar e = 0; e < DEPTH; e++) begin : g_ent
        mips_rf_wr_arb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_WR(NUM_WR)) u_arb (
            .wr_en   (wr_en),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .q_addr  (ADDR_W'(e)),
            .hit     (ent_hit[e]),
            .data    (ent_data[e])
        );
    end

    // pend_set is applied after the write-clear so a same-cycle set wins.
    always_comb begin
        mem_d  = mem_q;
        pend_d = pend_q;
        if (run) begin
            for (int e = 0; e < DEPTH; e++) begin
                if (ent_hit[e]) begin
                    mem_d[e]  = ent_data[e];
                    pend_d[e] = 1'b0;
                end
            end
            if (pend_set) pend_d[pend_addr] = 1'b1;
            if (ZERO_REG != 0) begin
                mem_d[0]  = '0;
                pend_d[0] = 1'b0;
            end
        end else begin
            mem_d[cnt_q]  = '0;
            pend_d[cnt_q] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        mem_q  <= mem_d;
        pend_q <= pend_d;
    end

    logic [NUM_RD-1:0]             rp_hit;
    logic [NUM_RD-1:0][DATA_W-1:0] rp_byp;
    logic [NUM_RD-1:0][DATA_W-1:0] rp_val;
    logic [NUM_RD-1:0][DATA_W-1:0] rd_data_q;
    logic [NUM_RD-1:0]             rd_pend_q;

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        assign ra = rd_addr[p*ADDR_W +: ADDR_W];

        mips_rf_wr_arb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_WR(NUM_WR)) u_arb (
            .wr_en   (wr_en),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .q_addr  (ra),
            .hit     (rp_hit[p]),
            .data    (rp_byp[p])
        );

        assign rp_val[p] = (ZERO_REG != 0 && ra == '0) ? '0 :
                           rp_hit[p] ? rp_byp[p] : mem_q[ra];
    end

    always_ff @(posedge clk) begin
        if (rst || !run) begin
            rd_data_q <= '0;
            rd_pend_q <= '0;
        end else begin
            for (int p = 0; p < NUM_RD; p++) begin
                if (rd_en[p]) begin
                    rd_data_q[p] <= rp_val[p];
                    rd_pend_q[p] <= pend_d[rd_addr[port_lsb(p, ADDR_W) +: ADDR_W]];
                end
            end
        end
    end

    assign rd_data = rd_data_q;
    assign rd_pend = rd_pend_q;

endmodule

// File: tb/tb_mips_regfile_mp.sv
// Scoreboard bench: reference model pushes expected read results each edge,
// a monitor pops and compares them half a cycle later.
module tb_mips_regfile_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  rd_en;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_pend;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        pend_set;
    logic [4:0]  pend_addr;
    logic        init_done;

    always #5 clk = ~clk;

    mips_regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_pend(rd_pend), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .pend_set(pend_set), .pend_addr(pend_addr), .init_done(init_done)
    );

    typedef struct {
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  p;
        logic        id;
    } exp_t;

    exp_t exp_q[$];
    int   vecs = 0;
    int   errs = 0;

    // Reference model: registers as a plain array, sweep as a count of cleared entries.
    bit [31:0] mem_m[32];
    bit        pend_m[32];
    int        clr_cnt = 0;
    bit        in_run  = 0;
    bit [31:0] e_d[2];
    bit        e_p[2];

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                clr_cnt = 0; in_run = 0;
                e_d[0] = 0; e_d[1] = 0; e_p[0] = 0; e_p[1] = 0;
            end else if (!in_run) begin
                mem_m[clr_cnt] = 0; pend_m[clr_cnt] = 0;
                clr_cnt++;
                if (clr_cnt == 32) in_run = 1;
                e_d[0] = 0; e_d[1] = 0; e_p[0] = 0; e_p[1] = 0;
            end else begin
                for (int w = 0; w < 2; w++) begin
                    if (wr_en[w] && wr_addr[w*5 +: 5] != 0) begin
                        mem_m[wr_addr[w*5 +: 5]]  = wr_data[w*32 +: 32];
                        pend_m[wr_addr[w*5 +: 5]] = 0;
                    end
                end
                if (pend_set && pend_addr != 0) pend_m[pend_addr] = 1;
                for (int p = 0; p < 2; p++) begin
                    if (rd_en[p]) begin
                        e_d[p] = mem_m[rd_addr[p*5 +: 5]];
                        e_p[p] = pend_m[rd_addr[p*5 +: 5]];
                    end
                end
            end
            exp_q.push_back('{e_d[0], e_d[1], {e_p[1], e_p[0]}, in_run});
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vecs += 4;
                if (rd_data[31:0] !== e.d0) begin
                    errs++; $display("FAIL rd_data0 t=%0t got %h want %h", $time, rd_data[31:0], e.d0);
                end
                if (rd_data[63:32] !== e.d1) begin
                    errs++; $display("FAIL rd_data1 t=%0t got %h want %h", $time, rd_data[63:32], e.d1);
                end
                if (rd_pend !== e.p) begin
                    errs++; $display("FAIL rd_pend t=%0t got %b want %b", $time, rd_pend, e.p);
                end
                if (init_done !== e.id) begin
                    errs++; $display("FAIL init_done t=%0t got %b want %b", $time, init_done, e.id);
                end
            end
        end
    end

    task automatic cyc(input logic r, input logic [1:0] re, input logic [4:0] ra0, input logic [4:0] ra1,
                       input logic [1:0] we, input logic [4:0] wa0, input logic [4:0] wa1,
                       input logic [31:0] wd0, input logic [31:0] wd1,
                       input logic ps, input logic [4:0] pa);
        rst = r; rd_en = re; rd_addr = {ra1, ra0};
        wr_en = we; wr_addr = {wa1, wa0}; wr_data = {wd1, wd0};
        pend_set = ps; pend_addr = pa;
        @(negedge clk);
    endtask

    function automatic logic [4:0] raddr();
        return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
    endfunction

    task automatic rnd(input logic r);
        cyc(r, 2'($urandom), raddr(), raddr(), 2'($urandom), raddr(), raddr(),
            $urandom, $urandom, 1'($urandom_range(0, 3) == 0), raddr());
    endtask

    initial begin
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // sweep: every read must return zero and init_done rises after 32 edges
        for (int i = 0; i < 40; i++)
            cyc(0, 2'b11, 5'(i), 5'(31 - i), 0, 0, 0, 0, 0, 0, 0);
        // write with same-cycle bypass, then re-read
        cyc(0, 2'b10, 0, 5, 2'b01, 5, 0, 32'hDEADBEEF, 0, 0, 0);
        cyc(0, 2'b11, 5, 5, 0, 0, 0, 0, 0, 0, 0);
        // write conflict: port 1 wins
        cyc(0, 2'b00, 0, 0, 2'b11, 9, 9, 32'h11, 32'h22, 0, 0);
        cyc(0, 2'b01, 9, 0, 0, 0, 0, 0, 0, 0, 0);
        // zero register
        cyc(0, 2'b00, 0, 0, 2'b01, 0, 0, 32'hFFFFFFFF, 0, 1, 0);
        cyc(0, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // pending set / clear / simultaneous
        cyc(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 3);
        cyc(0, 2'b01, 3, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 2'b00, 0, 0, 2'b10, 0, 3, 0, 32'h33, 0, 0);
        cyc(0, 2'b10, 0, 3, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 2'b11, 3, 3, 2'b01, 3, 0, 32'h1234ABCD, 0, 1, 3);
        cyc(0, 2'b11, 3, 3, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 300; i++) rnd(0);
        // reset mid-sweep with write traffic during the sweep
        rnd(1);
        for (int i = 0; i < 10; i++) rnd(0);
        rnd(1);
        for (int i = 0; i < 40; i++) rnd(0);
        for (int i = 0; i < 16; i++)
            cyc(0, 2'b11, 5'(2 * i), 5'(2 * i + 1), 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 200; i++) rnd(0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
